// File: rtl/set_head.sv
// set_head: snake head-position generator; define SETHEAD_WRAP_EN for toroidal borders, default saturates
module set_head #(
  parameter int X_MAX = 79,
  parameter int Y_MAX = 59
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] i_Way,
  input  logic [3:0] i_Push,
  input  logic [6:0] i_Head_x,
  input  logic [6:0] i_Head_y,
  output logic [6:0] o_Head_x,
  output logic [6:0] o_Head_y
);
  localparam logic [7:0] XM = X_MAX[7:0];
  localparam logic [7:0] YM = Y_MAX[7:0];
`ifdef SETHEAD_WRAP_EN
  localparam logic [7:0] X_LO = XM;
  localparam logic [7:0] X_HI = 8'd0;
  localparam logic [7:0] Y_LO = YM;
  localparam logic [7:0] Y_HI = 8'd0;
`else
  localparam logic [7:0] X_LO = 8'd0;
  localparam logic [7:0] X_HI = XM;
  localparam logic [7:0] Y_LO = 8'd0;
  localparam logic [7:0] Y_HI = YM;
`endif
  logic [3:0] w_pressed;
  logic [1:0] w_cand;
  logic [1:0] w_dir;
  logic [7:0] w_cx;
  logic [7:0] w_cy;
  logic [6:0] w_nx;
  logic [6:0] w_ny;
  logic [6:0] r_x;
  logic [6:0] r_y;
  // resolve direction (reversal rejected), clamp the head, then step one cell
  always_comb begin
    w_pressed = ~i_Push;
    w_cand = w_pressed[0] ? 2'd0 : w_pressed[1] ? 2'd1 : w_pressed[2] ? 2'd2 : 2'd3;
    w_dir = (w_pressed == 4'b0000 || w_cand == (i_Way ^ 2'b01)) ? i_Way : w_cand;
    w_cx = ({1'b0, i_Head_x} > XM) ? XM : {1'b0, i_Head_x};
    w_cy = ({1'b0, i_Head_y} > YM) ? YM : {1'b0, i_Head_y};
    w_nx = 7'(w_dir == 2'd2 ? (w_cx == 8'd0 ? X_LO : w_cx - 8'd1) :
              w_dir == 2'd3 ? (w_cx == XM ? X_HI : w_cx + 8'd1) : w_cx);
    w_ny = 7'(w_dir == 2'd0 ? (w_cy == 8'd0 ? Y_LO : w_cy - 8'd1) :
              w_dir == 2'd1 ? (w_cy == YM ? Y_HI : w_cy + 8'd1) : w_cy);
  end
  // register the next head every cycle; reset wins
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_x <= 7'd0;
      r_y <= 7'd0;
    end else begin
      r_x <= w_nx;
      r_y <= w_ny;
    end
  end
  assign o_Head_x = r_x;
  assign o_Head_y = r_y;
endmodule

// File: tb/tb_set_head.sv
// tb_set_head: directed self-checking bench for set_head
module tb_set_head;
`ifdef SETHEAD_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef struct {
    logic [6:0] x;
    logic [6:0] y;
    logic [1:0] way;
    logic [3:0] push;
    logic [6:0] ex;
    logic [6:0] ey;
  } vec_t;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [1:0] i_Way = 2'd0;
  logic [3:0] i_Push = 4'hF;
  logic [6:0] i_Head_x = 7'd0;
  logic [6:0] i_Head_y = 7'd0;
  logic [6:0] o_Head_x;
  logic [6:0] o_Head_y;
  int checks = 0;
  int errors = 0;
  set_head dut (
    .Clk(Clk), .Rst(Rst), .i_Way(i_Way), .i_Push(i_Push),
    .i_Head_x(i_Head_x), .i_Head_y(i_Head_y),
    .o_Head_x(o_Head_x), .o_Head_y(o_Head_y)
  );
  always #5 Clk = ~Clk;
  task automatic apply(input logic rst, input vec_t v);
    @(negedge Clk);
    Rst = rst;
    i_Head_x = v.x;
    i_Head_y = v.y;
    i_Way = v.way;
    i_Push = v.push;
    @(posedge Clk);
    #1;
  endtask
  task automatic test_reset;
    vec_t v;
    v = '{7'd5, 7'd5, 2'd3, 4'b0000, 7'd0, 7'd0};
    apply(1'b1, v);
    checks++;
    if ({o_Head_x, o_Head_y} !== {7'd0, 7'd0}) begin
      errors++;
      $display("FAIL reset got (%0d,%0d) want (0,0)", o_Head_x, o_Head_y);
    end
    v = '{7'd3, 7'd3, 2'd0, 4'b1111, 7'd3, 7'd2};
    apply(1'b0, v);
    checks++;
    if ({o_Head_x, o_Head_y} !== {v.ex, v.ey}) begin
      errors++;
      $display("FAIL reset_release got (%0d,%0d) want (%0d,%0d)", o_Head_x, o_Head_y, v.ex, v.ey);
    end
  endtask
  task automatic test_step;
    vec_t t[4];
    t = '{'{7'd1, 7'd1, 2'd0, 4'b1111, 7'd1, 7'd0},
          '{7'd1, 7'd1, 2'd3, 4'b1111, 7'd2, 7'd1},
          '{7'd10, 7'd20, 2'd1, 4'b1111, 7'd10, 7'd21},
          '{7'd10, 7'd20, 2'd2, 4'b1111, 7'd9, 7'd20}};
    foreach (t[i]) begin
      apply(1'b0, t[i]);
      checks++;
      if ({o_Head_x, o_Head_y} !== {t[i].ex, t[i].ey}) begin
        errors++;
        $display("FAIL step[%0d] got (%0d,%0d) want (%0d,%0d)", i, o_Head_x, o_Head_y, t[i].ex, t[i].ey);
      end
    end
  endtask
  task automatic test_buttons;
    vec_t t[7];
    t = '{'{7'd1, 7'd1, 2'd3, 4'b1110, 7'd1, 7'd0},
          '{7'd1, 7'd1, 2'd1, 4'b1110, 7'd1, 7'd2},
          '{7'd5, 7'd5, 2'd0, 4'b1011, 7'd4, 7'd5},
          '{7'd5, 7'd5, 2'd0, 4'b0111, 7'd6, 7'd5},
          '{7'd5, 7'd5, 2'd0, 4'b0000, 7'd5, 7'd4},
          '{7'd5, 7'd5, 2'd2, 4'b0111, 7'd4, 7'd5},
          '{7'd5, 7'd5, 2'd2, 4'b1011, 7'd4, 7'd5}};
    foreach (t[i]) begin
      apply(1'b0, t[i]);
      checks++;
      if ({o_Head_x, o_Head_y} !== {t[i].ex, t[i].ey}) begin
        errors++;
        $display("FAIL buttons[%0d] got (%0d,%0d) want (%0d,%0d)", i, o_Head_x, o_Head_y, t[i].ex, t[i].ey);
      end
    end
  endtask
  task automatic test_border;
    vec_t t[4];
    t = '{'{7'd0, 7'd0, 2'd2, 4'b1111, WRAP ? 7'd79 : 7'd0, 7'd0},
          '{7'd79, 7'd59, 2'd1, 4'b1111, 7'd79, WRAP ? 7'd0 : 7'd59},
          '{7'd0, 7'd0, 2'd0, 4'b1111, 7'd0, WRAP ? 7'd59 : 7'd0},
          '{7'd79, 7'd5, 2'd3, 4'b1111, WRAP ? 7'd0 : 7'd79, 7'd5}};
    foreach (t[i]) begin
      apply(1'b0, t[i]);
      checks++;
      if ({o_Head_x, o_Head_y} !== {t[i].ex, t[i].ey}) begin
        errors++;
        $display("FAIL border[%0d] got (%0d,%0d) want (%0d,%0d)", i, o_Head_x, o_Head_y, t[i].ex, t[i].ey);
      end
    end
  endtask
  task automatic test_clamp;
    vec_t t[3];
    t = '{'{7'd100, 7'd100, 2'd3, 4'b1111, WRAP ? 7'd0 : 7'd79, 7'd59},
          '{7'd127, 7'd127, 2'd2, 4'b1111, 7'd78, 7'd59},
          '{7'd127, 7'd127, 2'd0, 4'b1111, 7'd79, 7'd58}};
    foreach (t[i]) begin
      apply(1'b0, t[i]);
      checks++;
      if ({o_Head_x, o_Head_y} !== {t[i].ex, t[i].ey}) begin
        errors++;
        $display("FAIL clamp[%0d] got (%0d,%0d) want (%0d,%0d)", i, o_Head_x, o_Head_y, t[i].ex, t[i].ey);
      end
    end
  endtask
  task automatic test_back_to_back;
    vec_t v;
    v = '{7'd40, 7'd30, 2'd3, 4'b1111, 7'd41, 7'd30};
    apply(1'b0, v);
    checks++;
    if ({o_Head_x, o_Head_y} !== {v.ex, v.ey}) begin
      errors++;
      $display("FAIL b2b_run got (%0d,%0d) want (%0d,%0d)", o_Head_x, o_Head_y, v.ex, v.ey);
    end
    v = '{o_Head_x, o_Head_y, 2'd3, 4'b1101, 7'd41, 7'd31};
    apply(1'b0, v);
    checks++;
    if ({o_Head_x, o_Head_y} !== {v.ex, v.ey}) begin
      errors++;
      $display("FAIL b2b_turn got (%0d,%0d) want (%0d,%0d)", o_Head_x, o_Head_y, v.ex, v.ey);
    end
    v = '{7'd20, 7'd20, 2'd0, 4'b1111, 7'd0, 7'd0};
    apply(1'b1, v);
    checks++;
    if ({o_Head_x, o_Head_y} !== {7'd0, 7'd0}) begin
      errors++;
      $display("FAIL b2b_midreset got (%0d,%0d) want (0,0)", o_Head_x, o_Head_y);
    end
    Rst = 1'b0;
  endtask
  initial begin
    test_reset;
    test_step;
    test_buttons;
    test_border;
    test_clamp;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
